// File: rtl/rans_pkg.sv
// Shared constants, FSM state encoding and table entry layout for the rANS encoder.
package rans_pkg;

    localparam logic [31:0] L_INIT   = 32'h0080_0000;
    localparam int          BYTE_W   = 8;
    localparam int          RES_BITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_RENORM,
        ST_DIVIDE,
        ST_UPDATE,
        ST_FLUSH
    } rans_state_t;

    typedef struct packed {
        logic [RES_BITS:0]   freq;
        logic [RES_BITS-1:0] start;
    } freq_entry_t;

endpackage

// File: rtl/rans_divider.sv
// Restoring divider: 32-bit dividend by DIVW-bit divisor, one quotient bit per cycle.
module rans_divider #(
    parameter int DIVW = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [31:0]     dividend,
    input  logic [DIVW-1:0] divisor,
    output logic            done,
    output logic [31:0]     quotient,
    output logic [DIVW:0]   remainder
);

    logic            busy;
    logic [4:0]      cnt;
    logic [31:0]     quo;
    logic [DIVW:0]   rem;
    logic [DIVW-1:0] dvs;
    logic [DIVW:0]   trial;
    logic [DIVW:0]   diff;
    logic            fits;

    // Partial remainder stays below the divisor, so DIVW bits plus the incoming bit suffice.
    assign trial = {rem[DIVW-1:0], quo[31]};
    assign fits  = trial >= {1'b0, dvs};
    assign diff  = trial - {1'b0, dvs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= 5'd0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy <= 1'b1;
                cnt  <= 5'd0;
            end else if (busy) begin
                cnt <= cnt + 5'd1;
                if (cnt == 5'd31) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            quo <= dividend;
            rem <= '0;
            dvs <= divisor;
        end else if (busy) begin
            quo <= {quo[30:0], fits};
            rem <= fits ? diff : trial;
        end
    end

    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/rans_top.sv
// Byte-wise streaming rANS encoder: table lookup, renormalisation, divide, state update, flush.
module rans_top
    import rans_pkg::*;
#(
    parameter int RESOLUTION   = RES_BITS,
    parameter int SYMBOL_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tbl_we,
    input  logic [SYMBOL_WIDTH-1:0] tbl_addr,
    input  logic [RESOLUTION:0]     tbl_freq,
    input  logic [RESOLUTION-1:0]   tbl_start,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [SYMBOL_WIDTH-1:0] s_symbol,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [BYTE_W-1:0]       m_data,
    output logic                    m_last
);

    localparam int XSHIFT = 31 - RESOLUTION;

    rans_state_t state, state_next;
    logic [31:0] x, x_next;
    logic [1:0]  flush_cnt, flush_cnt_next;

    freq_entry_t mem [2**SYMBOL_WIDTH];
    freq_entry_t entry_q;
    logic [SYMBOL_WIDTH-1:0] sym_q;
    logic                    last_q;

    logic [31:0]         x_max;
    logic                out_free;
    logic                emit;
    logic                emit_last;
    logic [BYTE_W-1:0]   emit_data;
    logic                div_start;
    logic                div_done;
    logic [31:0]         div_q;
    logic [RESOLUTION+1:0] div_r;

    assign s_ready  = rst_n && (state == ST_IDLE);
    assign out_free = !m_valid || m_ready;
    // (L >> RESOLUTION) * 256 * freq collapses to a single left shift.
    assign x_max    = {{(31-RESOLUTION){1'b0}}, entry_q.freq} << XSHIFT;

    always_ff @(posedge clk) begin
        if (tbl_we)
            mem[tbl_addr] <= '{freq: tbl_freq, start: tbl_start};
        entry_q <= mem[sym_q];
        if (s_valid && s_ready) begin
            sym_q  <= s_symbol;
            last_q <= s_last;
        end
    end

    rans_divider #(.DIVW(RESOLUTION + 1)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (x),
        .divisor  (entry_q.freq),
        .done     (div_done),
        .quotient (div_q),
        .remainder(div_r)
    );

    always_comb begin
        state_next     = state;
        x_next         = x;
        flush_cnt_next = flush_cnt;
        emit           = 1'b0;
        emit_data      = '0;
        emit_last      = 1'b0;
        div_start      = 1'b0;
        case (state)
            ST_IDLE:   if (s_valid) state_next = ST_LOOKUP;
            ST_LOOKUP: state_next = ST_RENORM;
            ST_RENORM: begin
                if (x >= x_max) begin
                    if (out_free) begin
                        emit      = 1'b1;
                        emit_data = x[7:0];
                        x_next    = x >> 8;
                    end
                end else begin
                    div_start  = 1'b1;
                    state_next = ST_DIVIDE;
                end
            end
            ST_DIVIDE: if (div_done) state_next = ST_UPDATE;
            ST_UPDATE: begin
                x_next = (div_q << RESOLUTION)
                       + {{(30-RESOLUTION){1'b0}}, div_r}
                       + {{(32-RESOLUTION){1'b0}}, entry_q.start};
                flush_cnt_next = 2'd0;
                state_next     = last_q ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                if (out_free) begin
                    emit           = 1'b1;
                    emit_data      = 8'(x >> {flush_cnt, 3'b000});
                    emit_last      = (flush_cnt == 2'd3);
                    flush_cnt_next = flush_cnt + 2'd1;
                    if (flush_cnt == 2'd3) begin
                        x_next     = L_INIT;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            x         <= L_INIT;
            flush_cnt <= 2'd0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
        end else begin
            state     <= state_next;
            x         <= x_next;
            flush_cnt <= flush_cnt_next;
            // Output byte holds until taken; the FSM only loads it when the slot is free.
            if (emit) begin
                m_valid <= 1'b1;
                m_data  <= emit_data;
                m_last  <= emit_last;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rans_top.sv
// Randomised bench for rans_top: byte-level reference encoder plus software decoder round trip.
module tb_rans_top;

    localparam longint unsigned L  = 64'h80_0000;
    localparam int              RB = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tbl_we = 1'b0;
    logic [7:0] tbl_addr = '0;
    logic [10:0] tbl_freq = '0;
    logic [9:0] tbl_start = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_symbol = '0;
    logic       s_last = 1'b0;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_last;

    int n_checks = 0;
    int n_fail   = 0;
    int ready_mode = 0;

    int tfreq [256];
    int tstart [256];
    int slot2sym [1024];
    longint unsigned model_x = L;

    logic [8:0] exp_q [$];
    logic [8:0] got_q [$];
    logic [7:0] blk_bytes [$];
    int         blk_syms [$];

    rans_top dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tbl_we   (tbl_we),
        .tbl_addr (tbl_addr),
        .tbl_freq (tbl_freq),
        .tbl_start(tbl_start),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_symbol (s_symbol),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last)
    );

    always #5 clk = ~clk;

    // Sink: picks m_ready for the coming edge and logs the byte that edge will transfer.
    initial begin
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
            if (rst_n && m_valid && m_ready)
                got_q.push_back({m_last, m_data});
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, got %0d expected finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_tbl(input int sym, input int f, input int st);
        @(negedge clk);
        tbl_we    = 1'b1;
        tbl_addr  = 8'(sym);
        tbl_freq  = 11'(f);
        tbl_start = 10'(st);
        tfreq[sym]  = f;
        tstart[sym] = st;
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    task automatic enc_model(input int sym, input bit last);
        longint unsigned xv   = model_x;
        longint unsigned f    = longint'(tfreq[sym]);
        longint unsigned st   = longint'(tstart[sym]);
        longint unsigned xmax = ((L >> RB) * 256) * f;
        while (xv >= xmax) begin
            exp_q.push_back({1'b0, 8'(xv)});
            xv = xv >> 8;
        end
        xv = ((xv / f) << RB) + (xv % f) + st;
        if (last) begin
            for (int i = 0; i < 4; i++)
                exp_q.push_back({(i == 3), 8'(xv >> (8 * i))});
            xv = L;
        end
        model_x = xv;
    endtask

    task automatic send_sym(input int sym, input bit last);
        int t = 0;
        @(negedge clk);
        while (!s_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            chk("s_ready_timeout", {31'd0, s_ready}, 32'd1);
            return;
        end
        s_valid  = 1'b1;
        s_symbol = 8'(sym);
        s_last   = last;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        enc_model(sym, last);
    endtask

    task automatic drain_compare(input string tag);
        int t = 0;
        logic [8:0] e, g;
        while (!(got_q.size() >= exp_q.size() && s_ready && !m_valid) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            blk_bytes.push_back(g[7:0]);
            chk({tag, "_byte"}, {23'd0, g}, {23'd0, e});
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic decode_check();
        longint unsigned xv;
        int p = blk_bytes.size() - 1;
        int slot, s;
        if (p < 3) begin
            chk("dec_short", 32'(blk_bytes.size()), 32'd4);
            return;
        end
        xv = {32'd0, blk_bytes[p], blk_bytes[p-1], blk_bytes[p-2], blk_bytes[p-3]};
        p = p - 4;
        for (int i = blk_syms.size() - 1; i >= 0; i--) begin
            slot = int'(xv % 1024);
            s    = slot2sym[slot];
            xv   = longint'(tfreq[s]) * (xv >> RB) + longint'(slot) - longint'(tstart[s]);
            while (xv < L && p >= 0) begin
                xv = (xv << 8) | longint'(blk_bytes[p]);
                p--;
            end
            chk("dec_sym", 32'(s), 32'(blk_syms[i]));
        end
        chk("dec_final_x", 32'(xv), 32'(L));
        chk("dec_bytes_left", 32'(p + 1), 32'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data",  {24'd0, m_data},  32'd0);
        chk("rst_m_last",  {31'd0, m_last},  32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_s_ready", {31'd0, s_ready}, 32'd1);
        model_x = L;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic load_fixed();
        write_tbl(3, 512, 0);
        write_tbl(7, 1, 5);
        write_tbl(9, 1024, 0);
    endtask

    initial begin
        int held_d, held_l, rem, acc, sent, n;
        apply_reset();
        load_fixed();

        ready_mode = 0;
        send_sym(3, 1'b1);
        drain_compare("norenorm");

        send_sym(7, 1'b1);
        drain_compare("renorm");

        send_sym(9, 1'b1);
        drain_compare("fullfreq");

        // Backpressure during flush, with a non-trivial first flush byte.
        send_sym(7, 1'b0);
        drain_compare("bp_pre");
        ready_mode = 2;
        send_sym(3, 1'b1);
        begin
            int t = 0;
            while (!m_valid && t < 200) begin
                @(negedge clk);
                t++;
            end
        end
        chk("bp_valid", {31'd0, m_valid}, 32'd1);
        held_d = int'(m_data);
        held_l = int'(m_last);
        chk("bp_first_byte", 32'(held_d), 32'h05);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_data_stable", {24'd0, m_data}, 32'(held_d));
            chk("bp_last_stable", {31'd0, m_last}, 32'(held_l));
        end
        ready_mode = 0;
        drain_compare("bp");

        // Random normalised table and random block stream with random sink stalls.
        for (int s = 0; s < 256; s++) tfreq[s] = 1;
        for (int k = 0; k < 768; k++) tfreq[$urandom_range(0, 255)] += 1;
        acc = 0;
        for (int s = 0; s < 256; s++) begin
            write_tbl(s, tfreq[s], acc);
            for (int j = 0; j < tfreq[s]; j++) slot2sym[acc + j] = s;
            acc += tfreq[s];
        end
        ready_mode = 1;
        sent = 0;
        while (sent < 300) begin
            n = $urandom_range(1, 12);
            blk_syms.delete();
            blk_bytes.delete();
            for (int i = 0; i < n; i++) begin
                rem = $urandom_range(0, 255);
                blk_syms.push_back(rem);
                send_sym(rem, (i == n - 1));
            end
            drain_compare("rand");
            decode_check();
            sent += n;
        end

        // Asynchronous reset while the divider is running.
        ready_mode = 0;
        load_fixed();
        send_sym(7, 1'b0);
        drain_compare("ar_pre");
        ready_mode = 2;
        send_sym(7, 1'b1);
        repeat (10) @(negedge clk);
        chk("ar_pending_valid", {31'd0, m_valid}, 32'd1);
        chk("ar_pending_data",  {24'd0, m_data},  32'h05);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_m_valid", {31'd0, m_valid}, 32'd0);
        chk("ar_m_data",  {24'd0, m_data},  32'd0);
        chk("ar_m_last",  {31'd0, m_last},  32'd0);
        chk("ar_s_ready", {31'd0, s_ready}, 32'd0);
        ready_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        model_x = L;
        exp_q.delete();
        got_q.delete();
        load_fixed();
        send_sym(3, 1'b1);
        drain_compare("ar_post");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
